// File: rtl/instr_fetch_stage_pkg.sv
// rtl/instr_fetch_stage_pkg.sv - shared types and widths for the instruction fetch stage
package instr_fetch_stage_pkg;

  localparam int XLEN  = 64;
  localparam int ILEN  = 32;
  localparam int CTR_W = 4;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  function automatic logic pc_aligned(input logic [XLEN-1:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_stage_timeout_ctr.sv
// rtl/instr_fetch_stage_timeout_ctr.sv - memory response wait counter with terminal-count flag
module fetch_timeout_ctr
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam logic [CTR_W-1:0] TC_VAL = CTR_W'(MAX_WAIT);

  logic [CTR_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/instr_fetch_stage.sv
// rtl/instr_fetch_stage.sv - single-outstanding instruction fetch FSM with timeout and alignment fault
module instr_fetch_stage
  import instr_fetch_stage_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic            CLK,
  input  logic            Reset_L,
  input  logic [XLEN-1:0] startPC,
  input  logic [XLEN-1:0] NextPC,
  output logic [XLEN-1:0] CurrentPC,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemGnt,
  input  logic            IMemValid,
  input  logic [ILEN-1:0] IMemData,
  output logic            IfValid,
  input  logic            IfReady,
  output logic [XLEN-1:0] IfPC,
  output logic [ILEN-1:0] IfInstr,
  output logic            PCFault
);

  fetch_state_e state;
  logic         ctr_clr;
  logic         ctr_inc;
  logic         ctr_tc;

  assign ctr_clr = (state == ST_REQ) && IMemGnt;
  // Stop counting at terminal count; the FSM leaves WAIT on that cycle anyway.
  assign ctr_inc = (state == ST_WAIT) && !IMemValid && !ctr_tc;

  fetch_timeout_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timeout_ctr (
    .clk  (CLK),
    .rst_n(Reset_L),
    .clr  (ctr_clr),
    .inc  (ctr_inc),
    .tc   (ctr_tc)
  );

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state     <= ST_REQ;
      CurrentPC <= startPC;
      IfPC      <= '0;
      IfInstr   <= '0;
      PCFault   <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (IMemGnt) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A response on the terminal-count cycle still wins over the timeout.
          if (IMemValid) begin
            IfInstr <= IMemData;
            IfPC    <= CurrentPC;
            state   <= ST_HOLD;
          end else if (ctr_tc) begin
            PCFault <= 1'b1;
            state   <= ST_FAULT;
          end
        end
        ST_HOLD: begin
          if (IfReady) begin
            CurrentPC <= NextPC;
            if (pc_aligned(NextPC)) begin
              state <= ST_REQ;
            end else begin
              PCFault <= 1'b1;
              state   <= ST_FAULT;
            end
          end
        end
        default: begin
          PCFault <= 1'b1;
        end
      endcase
    end
  end

  assign IMemReq  = (state == ST_REQ);
  assign IfValid  = (state == ST_HOLD);
  assign IMemAddr = CurrentPC;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb/tb_instr_fetch_stage.sv - randomized scoreboard bench for instr_fetch_stage
module tb_instr_fetch_stage;

  localparam int unsigned MW = 3;

  logic        CLK = 1'b0;
  logic        Reset_L;
  logic [63:0] startPC;
  logic [63:0] NextPC;
  logic [63:0] CurrentPC;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemGnt;
  logic        IMemValid;
  logic [31:0] IMemData;
  logic        IfValid;
  logic        IfReady;
  logic [63:0] IfPC;
  logic [31:0] IfInstr;
  logic        PCFault;

  always #5 CLK = ~CLK;

  instr_fetch_stage #(.MAX_WAIT(MW)) dut (
    .CLK(CLK), .Reset_L(Reset_L), .startPC(startPC), .NextPC(NextPC),
    .CurrentPC(CurrentPC), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemGnt(IMemGnt), .IMemValid(IMemValid), .IMemData(IMemData),
    .IfValid(IfValid), .IfReady(IfReady), .IfPC(IfPC), .IfInstr(IfInstr),
    .PCFault(PCFault)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          exp_handoffs = 0;
  int          seen_handoffs = 0;
  logic [63:0] exp_pc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Handoff monitor: any IfValid&IfReady must match the oldest expected fetch.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      #2;
      if (Reset_L === 1'b1 && IfValid === 1'b1 && IfReady === 1'b1) begin
        seen_handoffs++;
        if (sb.size() == 0) begin
          chk("unexpected_handoff", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("ifpc", IfPC, e.pc);
          chk("ifinstr", 64'(IfInstr), 64'(e.instr));
        end
      end
    end
  end

  task automatic do_reset(input logic [63:0] pc);
    @(negedge CLK);
    startPC   = pc;
    Reset_L   = 1'b0;
    IMemGnt   = 1'b1;
    IMemValid = 1'b1;
    IfReady   = 1'b1;
    #1;
    chk("rst_imemreq", 64'(IMemReq), 64'd1);
    chk("rst_pc", CurrentPC, pc);
    chk("rst_pcfault", 64'(PCFault), 64'd0);
    chk("rst_ifvalid", 64'(IfValid), 64'd0);
    chk("rst_ifpc", IfPC, 64'd0);
    chk("rst_ifinstr", 64'(IfInstr), 64'd0);
    @(negedge CLK);
    Reset_L   = 1'b1;
    IMemGnt   = 1'b0;
    IMemValid = 1'b0;
    IfReady   = 1'b0;
    exp_pc    = pc;
  endtask

  task automatic fault_linger();
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("flt_pcfault", 64'(PCFault), 64'd1);
      chk("flt_imemreq", 64'(IMemReq), 64'd0);
      chk("flt_ifvalid", 64'(IfValid), 64'd0);
      chk("flt_pc", CurrentPC, exp_pc);
      IMemGnt   = 1'($urandom_range(0, 1));
      IMemValid = 1'($urandom_range(0, 1));
      IfReady   = 1'($urandom_range(0, 1));
      NextPC    = {$urandom, $urandom};
    end
  endtask

  // g: REQ cycles before grant, v: WAIT cycle index carrying the response
  // (v > MW means none), r: HOLD cycles before IfReady.
  task automatic run_txn(input int g, input int v, input int r,
                         input logic [31:0] data, input logic [63:0] nxt,
                         output bit faulted);
    faulted = 1'b0;
    for (int i = 0; i <= g; i++) begin
      @(negedge CLK);
      chk("req_imemreq", 64'(IMemReq), 64'd1);
      chk("req_addr", IMemAddr, exp_pc);
      chk("req_ifvalid", 64'(IfValid), 64'd0);
      IMemGnt   = (i == g);
      IMemValid = 1'($urandom_range(0, 1));
      IMemData  = $urandom;
      IfReady   = 1'($urandom_range(0, 1));
    end
    for (int k = 0; k <= int'(MW); k++) begin
      @(negedge CLK);
      chk("wait_imemreq", 64'(IMemReq), 64'd0);
      chk("wait_ifvalid", 64'(IfValid), 64'd0);
      IMemGnt = 1'($urandom_range(0, 1));
      IfReady = 1'($urandom_range(0, 1));
      if (k == v) begin
        IMemValid = 1'b1;
        IMemData  = data;
        sb.push_back('{exp_pc, data});
        exp_handoffs++;
        break;
      end
      IMemValid = 1'b0;
      IMemData  = $urandom;
    end
    if (v > int'(MW)) begin
      @(negedge CLK);
      chk("to_pcfault", 64'(PCFault), 64'd1);
      chk("to_imemreq", 64'(IMemReq), 64'd0);
      chk("to_ifvalid", 64'(IfValid), 64'd0);
      chk("to_pc", CurrentPC, exp_pc);
      faulted = 1'b1;
      return;
    end
    for (int j = 0; j <= r; j++) begin
      @(negedge CLK);
      chk("hold_ifvalid", 64'(IfValid), 64'd1);
      chk("hold_imemreq", 64'(IMemReq), 64'd0);
      chk("hold_pc", CurrentPC, exp_pc);
      IMemGnt   = 1'($urandom_range(0, 1));
      IMemValid = 1'($urandom_range(0, 1));
      IMemData  = $urandom;
      IfReady   = (j == r);
      NextPC    = (j == r) ? nxt : {$urandom, $urandom};
    end
    exp_pc = nxt;
    if (nxt[1:0] != 2'b00) begin
      @(negedge CLK);
      chk("mis_pcfault", 64'(PCFault), 64'd1);
      chk("mis_imemreq", 64'(IMemReq), 64'd0);
      chk("mis_pc", CurrentPC, nxt);
      faulted = 1'b1;
    end
  endtask

  task automatic reset_in_wait(input logic [63:0] pc);
    @(negedge CLK);
    chk("rw_req", 64'(IMemReq), 64'd1);
    IMemGnt = 1'b1;
    @(negedge CLK);
    chk("rw_wait", 64'(IMemReq), 64'd0);
    IMemGnt   = 1'b0;
    IMemValid = 1'b0;
    startPC   = pc;
    Reset_L   = 1'b0;
    @(negedge CLK);
    Reset_L   = 1'b1;
    IMemValid = 1'b1;
    IMemData  = $urandom;
    IfReady   = 1'b1;
    @(negedge CLK);
    chk("rw_ifvalid", 64'(IfValid), 64'd0);
    chk("rw_imemreq", 64'(IMemReq), 64'd1);
    chk("rw_addr", IMemAddr, pc);
    IMemValid = 1'b0;
    exp_pc    = pc;
  endtask

  initial begin
    bit          f;
    logic [63:0] nxt;
    int          v;
    Reset_L   = 1'b0;
    startPC   = 64'h400;
    NextPC    = '0;
    IMemGnt   = 1'b0;
    IMemValid = 1'b0;
    IMemData  = '0;
    IfReady   = 1'b0;
    exp_pc    = 64'h400;
    repeat (2) @(negedge CLK);

    do_reset(64'h400);
    run_txn(0, 0, 0, 32'h8B020020, 64'h404, f);
    run_txn(4, 1, 5, $urandom, 64'h408, f);
    run_txn(0, int'(MW), 0, $urandom, 64'h40C, f);
    run_txn(0, int'(MW) + 1, 0, $urandom, 64'h410, f);
    if (f) fault_linger();
    do_reset(64'h1000);
    run_txn(1, 0, 1, $urandom, 64'h402, f);
    if (f) fault_linger();
    do_reset(64'h2000);
    reset_in_wait(64'h3000);
    do_reset(64'hFFFF_FFFF_0000_0007);
    run_txn(0, 1, 0, $urandom, 64'h8000_0000_0000_0100, f);

    for (int n = 0; n < 40; n++) begin
      v = ($urandom_range(0, 7) == 0) ? int'(MW) + 1 : int'($urandom_range(0, MW));
      case ($urandom_range(0, 5))
        0:       nxt = {$urandom, $urandom} | 64'h1;
        1, 2:    nxt = {$urandom, $urandom} & ~64'h3;
        default: nxt = exp_pc + 64'd4;
      endcase
      run_txn(int'($urandom_range(0, 3)), v, int'($urandom_range(0, 3)), $urandom, nxt, f);
      if (f) begin
        fault_linger();
        do_reset({$urandom, $urandom} & ~64'h3);
      end
    end

    repeat (3) @(negedge CLK);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    chk("handoff_count", 64'(seen_handoffs), 64'(exp_handoffs));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch_stage.md
INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 Parameter: MAX_WAIT, default 15, sets the instruction-memory response timeout in cycles (range 1..15, 4-bit counter).
REQ-002 Port: CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: Reset_L  input  1  asynchronous, active-low reset.
REQ-004 Port: startPC  input  64  PC loaded while Reset_L is low.
REQ-005 Port: NextPC  input  64  next PC from the next-PC logic; sampled only at handoff.
REQ-006 Port: CurrentPC  output  64  registered PC; drives the next-PC logic and IMemAddr.
REQ-007 Port: IMemReq  output  1  fetch request to instruction memory.
REQ-008 Port: IMemAddr  output  64  fetch address; equals CurrentPC.
REQ-009 Port: IMemGnt  input  1  memory accepts the request this cycle.
REQ-010 Port: IMemValid  input  1  response data valid this cycle.
REQ-011 Port: IMemData  input  32  instruction word.
REQ-012 Port: IfValid  output  1  fetched instruction available downstream.
REQ-013 Port: IfReady  input  1  downstream accepts the instruction.
REQ-014 Port: IfPC  output  64  PC of the held instruction.
REQ-015 Port: IfInstr  output  32  held instruction word.
REQ-016 Port: PCFault  output  1  sticky fault flag (misaligned PC or timeout).

Function
REQ-017 The block SHALL implement a four-state FSM: REQ, WAIT, HOLD, FAULT.
REQ-018 In REQ: IMemReq=1; if IMemGnt=1, go to WAIT and clear the wait counter; otherwise stay in REQ.
REQ-019 In WAIT: if IMemValid=1, latch IMemData into IfInstr and CurrentPC into IfPC, then go to HOLD; otherwise increment the wait counter.
REQ-020 In WAIT: if the counter equals MAX_WAIT and IMemValid=0, go to FAULT; IMemValid=1 in that same cycle takes priority (go to HOLD).
REQ-021 In HOLD: IfValid=1; IfInstr and IfPC stay stable until handoff, defined as IfValid and IfReady both high.
REQ-022 On handoff: CurrentPC <= NextPC; if NextPC[1:0]!=2'b00, go to FAULT, otherwise go to REQ.
REQ-023 In FAULT: IMemReq=0 and IfValid=0; PCFault=1 until reset; CurrentPC holds the offending value.
REQ-024 IMemGnt is ignored outside REQ, and IMemValid is ignored outside WAIT.
REQ-025 IMemReq and IfValid SHALL be decoded from the state register only, with no combinational path from IfReady or IMemGnt.
REQ-026 Best-case throughput is one instruction per 3 cycles (REQ, WAIT, HOLD) with an immediate grant, valid on the next cycle, and IfReady held high.
REQ-027 All PC arithmetic is external; the block only registers and compares 64-bit values, with no truncation.

Reset
REQ-028 While Reset_L=0: state=REQ, CurrentPC=startPC, IfPC=0, IfInstr=0, wait counter=0, PCFault=0.
REQ-029 Because IMemReq is decoded from state, IMemReq=1 during reset; memory SHALL ignore requests while Reset_L=0.
REQ-030 Reset asserted mid-transaction (WAIT or HOLD) SHALL abandon the transaction; any IMemValid arriving after release while in REQ is ignored.
REQ-031 A startPC with bits [1:0] non-zero is not checked at reset; only NextPC is checked at handoff.

Structure
REQ-032 The shared package SHALL hold the FSM state encoding (2-bit: REQ=0, WAIT=1, HOLD=2, FAULT=3) and the 64/32-bit width constants.
REQ-033 One sub-module, fetch_timeout_ctr, SHALL implement the wait counter: clear, increment, and a terminal-count output compared against MAX_WAIT.

Verification
REQ-034 Reset with startPC=0x400, IMemGnt=1, IMemValid one cycle after grant, IMemData=0x8B020020, IfReady=1, NextPC=0x404 -> IfValid on cycle 3, IfPC=0x400, IfInstr=0x8B020020, then IMemAddr=0x404.
REQ-035 HOLD with IfReady=0 for 5 cycles -> IfValid, IfPC and IfInstr stable; CurrentPC unchanged until IfReady=1.
REQ-036 IMemGnt held low 4 cycles in REQ -> IMemReq stays 1 and IMemAddr stays stable; WAIT is entered only on the grant cycle.
REQ-037 MAX_WAIT=3 with no IMemValid -> FAULT after 4 WAIT cycles, PCFault=1; a variant with IMemValid on the terminal cycle -> HOLD, no fault.
REQ-038 Handoff with NextPC=0x402 -> FAULT, PCFault=1, CurrentPC=0x402, IMemReq=0; Reset_L pulse -> PCFault=0 and CurrentPC=startPC.
REQ-039 Reset_L asserted in WAIT, then released, with IMemValid=1 in the first post-reset cycle -> IfValid stays 0 and a fresh request is issued at startPC.
